regfile_sb: RTL and testbench

Parametrised general-purpose register file with an integrated write-pending scoreboard, sitting in the decode stage between instruction decode and the writeback path. It provides NUM_RD combinational read ports and one synchronous write port. It tracks outstanding writes per register and raises a stall when a source register still has a pending result. It succeeds the fixed 32×32, two-port decode register file with width, depth, port count and hazard tracking.

---
 rtl/regfile_sb.sv | 110 +++++++++++
 tb/tb_regfile_sb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with combinational reads and a per-register
// write-pending scoreboard; define REGFILE_BYPASS_EN for same-cycle writeback bypass.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     We,
  input  logic [ADDR_W-1:0]        Wadr,
  input  logic [DATA_W-1:0]        Wdata,
  input  logic [NUM_RD*ADDR_W-1:0] Radr,
  input  logic [NUM_RD-1:0]        Ren,
  output logic [NUM_RD*DATA_W-1:0] Rdata,
  input  logic                     Iss,
  input  logic [ADDR_W-1:0]        Iss_adr,
  output logic [NUM_RD-1:0]        Busy,
  output logic                     Stall
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q  [DEPTH];
  logic [CNT_W-1:0]  cnt_d  [DEPTH];
  logic [DEPTH-1:0]  inc;
  logic [DEPTH-1:0]  dec;

  logic wadr_zero;
  logic iss_zero;
  logic we_eff;
  logic iss_eff;

  // Register 0 is hard-wired when ZERO_REG is set: writes and issues to it vanish.
  assign wadr_zero = (ZERO_REG != 0) && (Wadr == '0);
  assign iss_zero  = (ZERO_REG != 0) && (Iss_adr == '0);
  assign we_eff    = We && !wadr_zero;
  assign iss_eff   = Iss && !Stall && !iss_zero;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_zero;
    logic [CNT_W-1:0]  cnt_rd;

    assign ra      = Radr[k*ADDR_W +: ADDR_W];
    assign ra_zero = (ZERO_REG != 0) && (ra == '0);
    assign cnt_rd  = cnt_q[ra];

`ifdef REGFILE_BYPASS_EN
    logic wr_hit;
    // A matching writeback forwards its data and retires one pending write now.
    assign wr_hit = we_eff && (Wadr == ra);
    assign Rdata[k*DATA_W +: DATA_W] = ra_zero ? '0 : (wr_hit ? Wdata : regs_q[ra]);
    assign Busy[k] = wr_hit ? (cnt_rd > CNT_W'(1)) : (cnt_rd != '0);
`else
    assign Rdata[k*DATA_W +: DATA_W] = ra_zero ? '0 : regs_q[ra];
    assign Busy[k] = (cnt_rd != '0);
`endif
  end

  assign Stall = (|(Busy & Ren)) || (Iss && (cnt_q[Iss_adr] == CNT_MAX));

  // One-hot increment/decrement requests for the scoreboard.
  always_comb begin
    inc = '0;
    dec = '0;
    if (iss_eff) begin
      inc[Iss_adr] = 1'b1;
    end
    if (we_eff && (cnt_q[Wadr] != '0)) begin
      dec[Wadr] = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < DEPTH; r++) begin
      cnt_d[r] = cnt_q[r];
      unique case ({inc[r], dec[r]})
        2'b10: begin
          if (cnt_q[r] != CNT_MAX) begin
            cnt_d[r] = cnt_q[r] + CNT_W'(1);
          end
        end
        2'b01:   cnt_d[r] = cnt_q[r] - CNT_W'(1);
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      if (we_eff) begin
        regs_q[Wadr] <= Wdata;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against an array/counter model,
// plus a wide/narrow parameter instance exercising three read ports.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] E_WB_RD    = BYP ? 32'h12 : 32'h0;
  localparam logic        E_WB_STALL = BYP ? 1'b0 : 1'b1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wadr = '0;
  logic [31:0] wdata = '0;
  logic [9:0]  radr = '0;
  logic [1:0]  ren = '0;
  logic [63:0] rdata;
  logic        iss = 1'b0;
  logic [4:0]  iss_adr = '0;
  logic [1:0]  busy;
  logic        stall;

  logic         we2 = 1'b0;
  logic [3:0]   wadr2 = '0;
  logic [63:0]  wdata2 = '0;
  logic [11:0]  radr2 = '0;
  logic [2:0]   ren2 = '0;
  logic [191:0] rdata2;
  logic         iss2 = 1'b0;
  logic [3:0]   iss_adr2 = '0;
  logic [2:0]   busy2;
  logic         stall2;

  regfile_sb u_dut (
    .CLK(CLK), .RST(RST), .We(we), .Wadr(wadr), .Wdata(wdata),
    .Radr(radr), .Ren(ren), .Rdata(rdata), .Iss(iss), .Iss_adr(iss_adr),
    .Busy(busy), .Stall(stall)
  );

  regfile_sb #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0)) u_dut2 (
    .CLK(CLK), .RST(RST), .We(we2), .Wadr(wadr2), .Wdata(wdata2),
    .Radr(radr2), .Ren(ren2), .Rdata(rdata2), .Iss(iss2), .Iss_adr(iss_adr2),
    .Busy(busy2), .Stall(stall2)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: plain register array plus a count of outstanding writes per register.
  logic [31:0] m_mem [32];
  int          m_cnt [32];
  logic [31:0] e_rd  [2];
  logic [1:0]  e_busy;
  bit          e_stall;

  always @(negedge CLK) begin
    #2;
    if (RST) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = '0;
        m_cnt[i] = 0;
      end
    end
    e_stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      int a;
      bit hit;
      int pend;
      a    = int'(radr[k*5 +: 5]);
      hit  = BYP && we && (int'(wadr) == a) && (a != 0);
      pend = m_cnt[a] - ((hit && m_cnt[a] > 0) ? 1 : 0);
      e_busy[k] = (pend != 0);
      e_rd[k]   = (a == 0) ? 32'h0 : (hit ? wdata : m_mem[a]);
      if (e_busy[k] && ren[k]) e_stall = 1'b1;
    end
    if (iss && m_cnt[iss_adr] == 3) e_stall = 1'b1;

    chk("rdata0", 64'(rdata[31:0]), 64'(e_rd[0]));
    chk("rdata1", 64'(rdata[63:32]), 64'(e_rd[1]));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("stall", 64'(stall), 64'(e_stall));

    if (!RST) begin
      if (we && wadr != 0) begin
        m_mem[wadr] = wdata;
        if (m_cnt[wadr] > 0) m_cnt[wadr]--;
      end
      if (iss && !e_stall && iss_adr != 0) m_cnt[iss_adr]++;
    end
  end

  task automatic drive(input bit w, input int wa, input logic [31:0] wd, input bit is,
                       input int ia, input logic [1:0] re, input int r0, input int r1);
    @(negedge CLK);
    we      = w;
    wadr    = 5'(wa);
    wdata   = wd;
    iss     = is;
    iss_adr = 5'(ia);
    ren     = re;
    radr    = {5'(r1), 5'(r0)};
  endtask

  task automatic idle();
    drive(1'b0, 0, 32'h0, 1'b0, 0, 2'b00, 0, 0);
  endtask

  logic [63:0] pat [16];

  initial begin
    for (int i = 0; i < 16; i++) pat[i] = {32'(i) * 32'h01010101, 32'hC0DE0000 | 32'(i)};

    // Reset
    idle();
    idle();
    #3;
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    idle();
    RST = 1'b0;

    drive(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 2'b01, 5, 0);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 2'b01, 5, 0);
    #3 chk("r5_read", 64'(rdata[31:0]), 64'hDEADBEEF);

    // Zero register
    drive(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 2'b11, 0, 0);
    #3 chk("zero_iss_stall", 64'(stall), 64'h0);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 2'b11, 0, 0);
    #3;
    chk("zero_rdata", rdata, 64'h0);
    chk("zero_busy", 64'(busy), 64'h0);
    chk("zero_stall", 64'(stall), 64'h0);

    // Hazard on r3
    drive(1'b0, 0, 32'h0, 1'b1, 3, 2'b00, 0, 0);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 2'b01, 3, 0);
    #3;
    chk("haz_busy", 64'(busy[0]), 64'h1);
    chk("haz_stall", 64'(stall), 64'h1);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 2'b01, 3, 0);
    #3 chk("haz_stall_hold", 64'(stall), 64'h1);
    drive(1'b1, 3, 32'h12, 1'b0, 0, 2'b01, 3, 0);
    #3;
    chk("haz_wb_stall", 64'(stall), 64'(E_WB_STALL));
    chk("haz_wb_rdata", 64'(rdata[31:0]), 64'(E_WB_RD));
    drive(1'b0, 0, 32'h0, 1'b0, 0, 2'b01, 3, 0);
    #3;
    chk("haz_after_stall", 64'(stall), 64'h0);
    chk("haz_after_rdata", 64'(rdata[31:0]), 64'h12);

    // Multiple pending on r7
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, 32'h0, 1'b1, 7, 2'b00, 0, 0);
      #3 chk("multi_iss_stall", 64'(stall), 64'h0);
    end
    drive(1'b0, 0, 32'h0, 1'b1, 7, 2'b00, 0, 0);
    #3 chk("multi_full_stall", 64'(stall), 64'h1);
    drive(1'b1, 7, 32'hA1, 1'b0, 0, 2'b00, 0, 0);
    drive(1'b1, 7, 32'hA2, 1'b0, 0, 2'b00, 0, 0);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 2'b01, 7, 0);
    #3 chk("multi_busy_left", 64'(busy[0]), 64'h1);
    drive(1'b1, 7, 32'hA3, 1'b0, 0, 2'b00, 0, 0);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 2'b01, 7, 0);
    #3;
    chk("multi_busy_clear", 64'(busy[0]), 64'h0);
    chk("multi_rdata", 64'(rdata[31:0]), 64'hA3);

    // Simultaneous issue and writeback on r4, then a write with nothing pending
    drive(1'b0, 0, 32'h0, 1'b1, 4, 2'b00, 0, 0);
    drive(1'b1, 4, 32'h44, 1'b1, 4, 2'b00, 0, 0);
    #3 chk("sim_stall", 64'(stall), 64'h0);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 2'b00, 4, 0);
    #3;
    chk("sim_busy", 64'(busy[0]), 64'h1);
    chk("sim_rdata", 64'(rdata[31:0]), 64'h44);
    drive(1'b1, 4, 32'h45, 1'b0, 0, 2'b00, 0, 0);
    drive(1'b1, 9, 32'h99, 1'b0, 0, 2'b00, 0, 0);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 2'b11, 9, 4);
    #3;
    chk("r9_rdata", 64'(rdata[31:0]), 64'h99);
    chk("r4_rdata", 64'(rdata[63:32]), 64'h45);
    chk("idle_busy", 64'(busy), 64'h0);

    // Random traffic with a two-cycle reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500 || i == 1501) begin
        idle();
        RST = 1'b1;
        if (i == 1501) begin
          #3;
          chk("midrst_rdata", rdata, 64'h0);
          chk("midrst_busy", 64'(busy), 64'h0);
          chk("midrst_stall", 64'(stall), 64'h0);
        end
      end else begin
        drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)));
        RST = 1'b0;
      end
    end
    idle();

    // Wide/narrow instance: fill all 16 registers, read back on three ports
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      we2    = 1'b1;
      wadr2  = 4'(i);
      wdata2 = pat[i];
    end
    @(negedge CLK);
    we2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      radr2 = {4'((i + 11) % 16), 4'((i + 5) % 16), 4'(i)};
      #3;
      chk("p3_port0", rdata2[63:0], pat[i]);
      chk("p3_port1", rdata2[127:64], pat[(i + 5) % 16]);
      chk("p3_port2", rdata2[191:128], pat[(i + 11) % 16]);
    end
    chk("p3_busy", 64'(busy2), 64'h0);
    chk("p3_stall", 64'(stall2), 64'h0);

    idle();
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
